// File: rtl/calc_entry_ctrl.sv
// Keypad entry controller for a 4-function calculator: builds two 8-bit operands
// from decimal keys, hands them to an external ALU and holds/display the result.
//
// state    | meaning
// ENTER_A  | typing first operand
// ENTER_B  | typing second operand, operator latched
// WAIT_ALU | alu_start issued, waiting for alu_done or timeout
// RESULT   | showing ALU result, ready to chain or start over
// ERROR    | ALU error or timeout, only clear key exits
module calc_entry_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  input  logic       alu_error,
  output logic [7:0] operand_a,
  output logic [7:0] operand_b,
  output logic [1:0] alu_op,
  output logic       alu_start,
  output logic [7:0] disp_value,
  output logic       error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    WAIT_ALU = 3'd2,
    RESULT   = 3'd3,
    ERROR    = 3'd4
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d, err_q, err_d;

  logic          is_digit, is_op, is_eq, is_clr, do_clear;
  logic [1:0]    key_op;
  logic [11:0]   acc_a, acc_b;
  logic [7:0]    a_acc, b_acc;

  assign is_digit = key_valid && (key_value <= 4'd9);
  assign is_op    = key_valid && (key_value >= 4'hA) && (key_value <= 4'hD);
  assign is_eq    = key_valid && (key_value == 4'hE);
  assign is_clr   = key_valid && (key_value == 4'hF);
  assign key_op   = 2'(key_value - 4'hA);

  // 12-bit accumulation so an overflowing digit can be detected and dropped
  assign acc_a = {4'd0, a_q} * 12'd10 + {8'd0, key_value};
  assign acc_b = {4'd0, b_q} * 12'd10 + {8'd0, key_value};
  assign a_acc = (acc_a > 12'd255) ? a_q : acc_a[7:0];
  assign b_acc = (acc_b > 12'd255) ? b_q : acc_b[7:0];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    do_clear = 1'b0;

    case (state_q)
      ENTER_A: begin
        if (is_digit) begin
          a_d = a_acc;
        end else if (is_op) begin
          op_d    = key_op;
          b_d     = 8'd0;
          state_d = ENTER_B;
        end else if (is_clr) begin
          a_d = 8'd0;
        end
      end
      ENTER_B: begin
        if (is_digit) begin
          b_d = b_acc;
        end else if (is_op) begin
          op_d = key_op;
        end else if (is_eq) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_ALU;
        end else if (is_clr) begin
          do_clear = 1'b1;
        end
      end
      WAIT_ALU: begin
        // clear beats a simultaneous alu_done; alu_done beats the last timeout cycle
        if (is_clr) begin
          do_clear = 1'b1;
        end else if (alu_done) begin
          if (alu_error) begin
            state_d = ERROR;
          end else begin
            res_d   = alu_result;
            state_d = RESULT;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESULT: begin
        if (is_digit) begin
          a_d     = 8'(key_value);
          state_d = ENTER_A;
        end else if (is_op) begin
          a_d     = res_q;
          op_d    = key_op;
          b_d     = 8'd0;
          state_d = ENTER_B;
        end else if (is_clr) begin
          do_clear = 1'b1;
        end
      end
      ERROR: begin
        if (is_clr) do_clear = 1'b1;
      end
      default: do_clear = 1'b1;
    endcase

    if (do_clear) begin
      a_d     = 8'd0;
      b_d     = 8'd0;
      op_d    = 2'd0;
      res_d   = 8'd0;
      cnt_d   = '0;
      state_d = ENTER_A;
    end

    case (state_d)
      ENTER_A:           disp_d = a_d;
      ENTER_B, WAIT_ALU: disp_d = b_d;
      RESULT:            disp_d = res_d;
      default:           disp_d = 8'd0;
    endcase
    err_d = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTER_A;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      op_q    <= 2'd0;
      res_q   <= 8'd0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      disp_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
    end
  end

  assign operand_a  = a_q;
  assign operand_b  = b_q;
  assign alu_op     = op_q;
  assign alu_start  = start_q;
  assign disp_value = disp_q;
  assign error      = err_q;
  assign state      = state_q;

endmodule
